nn_ahb_cmdq_regbank: RTL and testbench

//  AHB-lite slave register bank for the NN accelerator; successor of the fixed-map NN config interface.

---
 rtl/nn_ahb_cmdq_regbank_if.sv | 24 ++
 rtl/nn_ahb_cmdq_regbank.sv | 213 +++++++++++++++++++++
 tb/tb_nn_ahb_cmdq_regbank.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/nn_ahb_cmdq_regbank_if.sv
// AHB-lite bus bundle between the CPU matrix (master) and the NN command/config register bank (slave).
interface nn_ahb_cmdq_regbank_if #(
    parameter int ADDR_W = 12
);
    logic              HSEL;
    logic              HREADY;
    logic [1:0]        HTRANS;
    logic              HWRITE;
    logic [ADDR_W-1:0] HADDR;
    logic [31:0]       HWDATA;
    logic [31:0]       HRDATA;
    logic              HREADYOUT;
    logic              HRESP;

    modport master (
        output HSEL, HREADY, HTRANS, HWRITE, HADDR, HWDATA,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HREADY, HTRANS, HWRITE, HADDR, HWDATA,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/nn_ahb_cmdq_regbank.sv
// AHB-lite register bank for the NN accelerator: CFG array, command FIFO and masked W1C interrupts.
// Optional NN_AHB_ERR_RESP_EN: two-cycle ERROR response for unmapped accesses and pushes into a full FIFO.
module nn_ahb_cmdq_regbank #(
    parameter int ADDR_W    = 12,
    parameter int NUM_CFG   = 8,
    parameter int CMD_W     = 8,
    parameter int CMD_DEPTH = 4,
    parameter int NUM_IRQ   = 4
) (
    input  logic                   nn_clk,
    input  logic                   nn_rst,
    nn_ahb_cmdq_regbank_if.slave   bus,
    input  logic [15:0]            core_sr,
    input  logic [NUM_IRQ-1:0]     irq_src,
    output logic                   cmd_valid,
    input  logic                   cmd_ready,
    output logic [CMD_W-1:0]       cmd_data,
    output logic                   nn_enable,
    output logic [31:0]            random_seed,
    output logic [NUM_CFG*32-1:0]  cfg_flat,
    output logic                   nn_interrupt
);
    localparam int WA_W  = ADDR_W - 2;
    localparam int PTR_W = $clog2(CMD_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [WA_W-1:0] A_CR   = WA_W'(0);
    localparam logic [WA_W-1:0] A_SR   = WA_W'(1);
    localparam logic [WA_W-1:0] A_ISR  = WA_W'(2);
    localparam logic [WA_W-1:0] A_IMR  = WA_W'(3);
    localparam logic [WA_W-1:0] A_CMD  = WA_W'(4);
    localparam logic [WA_W-1:0] A_SEED = WA_W'(5);
    localparam logic [WA_W-1:0] A_CFG0 = WA_W'(8);

    logic                       accept, wr_en, flush, push, pop, push_ok, full, empty, mem_we;
    logic [WA_W-1:0]            haddr_w;
    logic                       valid_q, valid_d, write_q, write_d;
    logic [WA_W-1:0]            addr_q, addr_d;
    logic [1:0]                 cr_q, cr_d;
    logic [NUM_IRQ-1:0]         isr_q, isr_d, isr_clr, imr_q, imr_d;
    logic [31:0]                seed_q, seed_d, hrdata_q, hrdata_d;
    logic [NUM_CFG-1:0][31:0]   cfg_q, cfg_d;
    logic [CMD_W-1:0]           mem_q [CMD_DEPTH];
    logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic                       ovf_q, ovf_d, nn_int_q, nn_int_d;
    logic                       unused_bits;

    assign accept      = bus.HSEL & bus.HREADY & bus.HTRANS[1];
    assign haddr_w     = bus.HADDR[ADDR_W-1:2];
    assign wr_en       = valid_q & write_q;
    assign unused_bits = ^{bus.HADDR[1:0], bus.HTRANS[0]};

    always_comb begin
        valid_d  = accept;
        write_d  = accept & bus.HWRITE;
        addr_d   = accept ? haddr_w : addr_q;
        cr_d     = cr_q;
        imr_d    = imr_q;
        seed_d   = seed_q;
        cfg_d    = cfg_q;
        isr_clr  = '0;
        flush    = 1'b0;
        push     = 1'b0;
        if (wr_en) begin
            case (addr_q)
                A_CR: begin
                    cr_d  = bus.HWDATA[1:0];
                    flush = bus.HWDATA[2];
                end
                A_ISR:  isr_clr = bus.HWDATA[NUM_IRQ-1:0];
                A_IMR:  imr_d   = bus.HWDATA[NUM_IRQ-1:0];
                A_CMD:  push    = 1'b1;
                A_SEED: seed_d  = bus.HWDATA;
                default: begin
                    for (int i = 0; i < NUM_CFG; i++)
                        if (addr_q == A_CFG0 + WA_W'(i)) cfg_d[i] = bus.HWDATA;
                end
            endcase
        end
        // A live request level re-sets its bit even while software clears it.
        isr_d    = (isr_q & ~isr_clr) | irq_src;
        nn_int_d = cr_q[1] & |(isr_q & imr_q);
    end

    assign full      = (count_q == CNT_W'(CMD_DEPTH));
    assign empty     = (count_q == '0);
    assign cmd_valid = cr_q[0] & ~empty;
    assign pop       = cmd_valid & cmd_ready;
    assign push_ok   = push & (~full | pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        mem_we   = 1'b0;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            if (push & full & ~pop) ovf_d = 1'b1;
            if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push_ok) begin
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop);
        end
    end

    // Read data comes from the post-write values so a read right behind a write sees the new data.
    always_comb begin
        hrdata_d = '0;
        if (accept & ~bus.HWRITE) begin
            case (haddr_w)
                A_CR:   hrdata_d = {30'b0, cr_d};
                A_SR:   hrdata_d = {core_sr, 5'b0, ovf_q, empty, full, 8'(count_q)};
                A_ISR:  hrdata_d = 32'(isr_d);
                A_IMR:  hrdata_d = 32'(imr_d);
                A_SEED: hrdata_d = seed_d;
                default: begin
                    for (int i = 0; i < NUM_CFG; i++)
                        if (haddr_w == A_CFG0 + WA_W'(i)) hrdata_d = cfg_d[i];
                end
            endcase
        end
    end

`ifdef NN_AHB_ERR_RESP_EN
    localparam logic [0:0] ST_OK   = 1'b0;
    localparam logic [0:0] ST_ERR2 = 1'b1;

    logic       unmapped_q, unmapped_d, data_err;
    logic [0:0] st_q, st_d;

    function automatic logic is_mapped(input logic [WA_W-1:0] a);
        logic hit;
        hit = (a <= A_SEED);
        for (int i = 0; i < NUM_CFG; i++)
            if (a == A_CFG0 + WA_W'(i)) hit = 1'b1;
        return hit;
    endfunction

    // First error cycle is the data phase itself, stretched by HREADYOUT low.
    always_comb begin
        unmapped_d = accept & ~is_mapped(haddr_w);
        data_err   = valid_q & (unmapped_q | (push & full & ~pop));
        st_d       = data_err ? ST_ERR2 : ST_OK;
    end

    always_ff @(posedge nn_clk or posedge nn_rst) begin
        if (nn_rst) begin
            unmapped_q <= 1'b0;
            st_q       <= ST_OK;
        end else begin
            unmapped_q <= unmapped_d;
            st_q       <= st_d;
        end
    end

    assign bus.HREADYOUT = ~data_err;
    assign bus.HRESP     = data_err | (st_q == ST_ERR2);
`else
    assign bus.HREADYOUT = 1'b1;
    assign bus.HRESP     = 1'b0;
`endif

    always_ff @(posedge nn_clk or posedge nn_rst) begin
        if (nn_rst) begin
            valid_q  <= 1'b0;
            write_q  <= 1'b0;
            addr_q   <= '0;
            cr_q     <= '0;
            isr_q    <= '0;
            imr_q    <= '0;
            seed_q   <= 32'd1;
            cfg_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            nn_int_q <= 1'b0;
            hrdata_q <= '0;
            for (int i = 0; i < CMD_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            valid_q  <= valid_d;
            write_q  <= write_d;
            addr_q   <= addr_d;
            cr_q     <= cr_d;
            isr_q    <= isr_d;
            imr_q    <= imr_d;
            seed_q   <= seed_d;
            cfg_q    <= cfg_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            nn_int_q <= nn_int_d;
            hrdata_q <= hrdata_d;
            if (mem_we) mem_q[wr_ptr_q] <= bus.HWDATA[CMD_W-1:0];
        end
    end

    assign bus.HRDATA   = hrdata_q;
    assign cmd_data     = empty ? '0 : mem_q[rd_ptr_q];
    assign nn_enable    = cr_q[0];
    assign random_seed  = seed_q;
    assign cfg_flat     = cfg_q;
    assign nn_interrupt = nn_int_q;
endmodule

// File: tb/tb_nn_ahb_cmdq_regbank.sv
// Scoreboard bench for nn_ahb_cmdq_regbank: read responses and popped commands are checked by monitors.
module tb_nn_ahb_cmdq_regbank;
    logic         nn_clk = 1'b0;
    logic         nn_rst;
    logic [15:0]  core_sr;
    logic [3:0]   irq_src;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [7:0]   cmd_data;
    logic         nn_enable;
    logic [31:0]  random_seed;
    logic [255:0] cfg_flat;
    logic         nn_interrupt;

    int checks = 0;
    int passes = 0;

    typedef struct {
        string       name;
        logic [31:0] data;
        logic        resp;
    } rd_exp_t;

    rd_exp_t    rd_q[$];
    logic [7:0] cmd_q[$];
    rd_exp_t    mon_e;
    logic [7:0] mon_c;
    logic       rd_pending;

    nn_ahb_cmdq_regbank_if #(.ADDR_W(12)) bus ();

    nn_ahb_cmdq_regbank dut (
        .nn_clk       (nn_clk),
        .nn_rst       (nn_rst),
        .bus          (bus),
        .core_sr      (core_sr),
        .irq_src      (irq_src),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_data     (cmd_data),
        .nn_enable    (nn_enable),
        .random_seed  (random_seed),
        .cfg_flat     (cfg_flat),
        .nn_interrupt (nn_interrupt)
    );

    always #5 nn_clk = ~nn_clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Read data phase tracker: a read stays pending until the slave shows HREADYOUT.
    always @(posedge nn_clk or posedge nn_rst) begin
        if (nn_rst) rd_pending <= 1'b0;
        else if (bus.HSEL & bus.HREADY & bus.HTRANS[1] & ~bus.HWRITE) rd_pending <= 1'b1;
        else if (bus.HREADYOUT) rd_pending <= 1'b0;
    end

    // Monitor: compares read responses and popped commands against the scoreboard queues.
    always @(negedge nn_clk) begin
        if (!nn_rst && rd_pending && bus.HREADYOUT) begin
            if (rd_q.size() == 0) begin
                checks++;
                $display("[TB] FAIL rd_unexpected: got read data 0x%08h, expected no read", bus.HRDATA);
            end else begin
                mon_e = rd_q.pop_front();
                checkOutput({mon_e.name, "_data"}, bus.HRDATA, mon_e.data);
                checkOutput({mon_e.name, "_resp"}, 32'(bus.HRESP), 32'(mon_e.resp));
            end
        end
        if (!nn_rst && cmd_valid && cmd_ready) begin
            if (cmd_q.size() == 0) begin
                checks++;
                $display("[TB] FAIL cmd_unexpected: got cmd 0x%02h, expected no pop", cmd_data);
            end else begin
                mon_c = cmd_q.pop_front();
                checkOutput("cmd_pop", 32'(cmd_data), 32'(mon_c));
            end
        end
    end

    task automatic waitDataPhase(input string name);
        logic rdy;
        int   n = 0;
        do begin
            rdy = bus.HREADYOUT;
            @(posedge nn_clk); #1;
            n++;
        end while (!rdy && n < 8);
        if (!rdy) begin
            checks++;
            $display("[TB] FAIL %s_timeout: got HREADYOUT low for %0d cycles, expected completion", name, n);
        end
    endtask

    // One AHB transfer followed by idle; called at posedge+1, returns at posedge+1 after the data phase.
    task automatic applyStimulus(input logic wr, input logic [11:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] exp_rd, input string name);
        if (!wr) rd_q.push_back('{name: name, data: exp_rd, resp: 1'b0});
        bus.HSEL   = 1'b1;
        bus.HTRANS = 2'b10;
        bus.HWRITE = wr;
        bus.HADDR  = addr;
        @(posedge nn_clk); #1;
        bus.HSEL   = 1'b0;
        bus.HTRANS = 2'b00;
        bus.HWRITE = 1'b0;
        bus.HWDATA = wdata;
        waitDataPhase(name);
    endtask

    task automatic ahbWrite(input logic [11:0] addr, input logic [31:0] wdata);
        applyStimulus(1'b1, addr, wdata, 32'h0, "wr");
    endtask

    task automatic ahbRead(input logic [11:0] addr, input logic [31:0] exp, input string name);
        applyStimulus(1'b0, addr, 32'h0, exp, name);
    endtask

    task automatic drainFour(input string name);
        cmd_ready = 1'b1;
        repeat (4) @(posedge nn_clk);
        #1;
        checkOutput({name, "_valid_low"}, 32'(cmd_valid), 32'h0);
        cmd_ready = 1'b0;
    endtask

    initial begin
        nn_rst     = 1'b1;
        core_sr    = 16'h5A3C;
        irq_src    = '0;
        cmd_ready  = 1'b0;
        bus.HSEL   = 1'b0;
        bus.HREADY = 1'b1;
        bus.HTRANS = 2'b00;
        bus.HWRITE = 1'b0;
        bus.HADDR  = '0;
        bus.HWDATA = '0;
        repeat (3) @(posedge nn_clk);
        #1;
        checkOutput("rst_nn_interrupt", 32'(nn_interrupt), 32'h0);
        checkOutput("rst_cmd_valid", 32'(cmd_valid), 32'h0);
        checkOutput("rst_cmd_data", 32'(cmd_data), 32'h0);
        checkOutput("rst_hrdata", bus.HRDATA, 32'h0);
        checkOutput("rst_hreadyout", 32'(bus.HREADYOUT), 32'h1);
        checkOutput("rst_hresp", 32'(bus.HRESP), 32'h0);
        checkOutput("rst_seed_port", random_seed, 32'h1);
        nn_rst = 1'b0;
        @(posedge nn_clk); #1;

        ahbRead(12'h014, 32'h0000_0001, "rst_seed");
        ahbRead(12'h004, 32'h5A3C_0200, "rst_sr");

        // Overfill a stalled FIFO, then drain it
        ahbWrite(12'h000, 32'h1);
        checkOutput("nn_enable", 32'(nn_enable), 32'h1);
        foreach (cmd_q[i]) cmd_q.delete(i);
        cmd_q.push_back(8'hA1); cmd_q.push_back(8'hA2);
        cmd_q.push_back(8'hA3); cmd_q.push_back(8'hA4);
        for (int i = 1; i <= 5; i++) ahbWrite(12'h010, 32'hA0 + 32'(i));
        checkOutput("full_head", 32'(cmd_data), 32'hA1);
        ahbRead(12'h004, 32'h5A3C_0504, "sr_full_ovf");
        drainFour("drainA");
        ahbRead(12'h004, 32'h5A3C_0600, "sr_empty_ovf");
        ahbWrite(12'h000, 32'h5);
        ahbRead(12'h004, 32'h5A3C_0200, "sr_flushed");
        ahbRead(12'h000, 32'h0000_0001, "cr_flush_rd0");
        ahbRead(12'h010, 32'h0, "cmd_rd0");

        // Push into a full FIFO in the same cycle as a pop
        cmd_q.push_back(8'hC1); cmd_q.push_back(8'hC2); cmd_q.push_back(8'hC3);
        cmd_q.push_back(8'hC4); cmd_q.push_back(8'hB0);
        for (int i = 1; i <= 4; i++) ahbWrite(12'h010, 32'hC0 + 32'(i));
        bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b1; bus.HADDR = 12'h010;
        @(posedge nn_clk); #1;
        bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0; bus.HWDATA = 32'hB0;
        cmd_ready = 1'b1;
        @(posedge nn_clk); #1;
        cmd_ready = 1'b0;
        ahbRead(12'h004, 32'h5A3C_0104, "sr_full_pushpop");
        drainFour("drainB");

        // Interrupt set, set-over-clear and clear
        ahbWrite(12'h00C, 32'h5);
        ahbWrite(12'h000, 32'h2);
        irq_src = 4'h4;
        @(posedge nn_clk); #1;
        irq_src = 4'h0;
        checkOutput("irq_lag", 32'(nn_interrupt), 32'h0);
        @(posedge nn_clk); #1;
        checkOutput("irq_set", 32'(nn_interrupt), 32'h1);
        ahbRead(12'h008, 32'h4, "isr_set");
        bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b1; bus.HADDR = 12'h008;
        @(posedge nn_clk); #1;
        bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0; bus.HWDATA = 32'h4;
        irq_src = 4'h4;
        @(posedge nn_clk); #1;
        irq_src = 4'h0;
        ahbRead(12'h008, 32'h4, "isr_set_wins");
        ahbRead(12'h00C, 32'h5, "imr_rd");
        ahbWrite(12'h008, 32'h4);
        checkOutput("irq_hold", 32'(nn_interrupt), 32'h1);
        @(posedge nn_clk); #1;
        checkOutput("irq_clear", 32'(nn_interrupt), 32'h0);
        ahbRead(12'h008, 32'h0, "isr_cleared");

        // CFG top word with back-to-back write then read
        rd_q.push_back('{name: "cfg7_b2b", data: 32'hDEAD_BEEF, resp: 1'b0});
        bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b1; bus.HADDR = 12'h03C;
        @(posedge nn_clk); #1;
        bus.HWRITE = 1'b0; bus.HADDR = 12'h03C; bus.HWDATA = 32'hDEAD_BEEF;
        @(posedge nn_clk); #1;
        bus.HSEL = 1'b0; bus.HTRANS = 2'b00;
        @(posedge nn_clk); #1;
        checkOutput("cfg_flat_top", cfg_flat[255:224], 32'hDEAD_BEEF);
        ahbWrite(12'h020, 32'h1234_5678);
        checkOutput("cfg_flat_low", cfg_flat[31:0], 32'h1234_5678);
        ahbRead(12'h020, 32'h1234_5678, "cfg0_rd");
        ahbWrite(12'h014, 32'hCAFE_F00D);
        checkOutput("seed_port", random_seed, 32'hCAFE_F00D);
        ahbRead(12'h014, 32'hCAFE_F00D, "seed_rd");
        ahbRead(12'h018, 32'h0, "hole_rd0");

        // First address past the CFG array
`ifdef NN_AHB_ERR_RESP_EN
        rd_q.push_back('{name: "unmapped", data: 32'h0, resp: 1'b1});
`else
        rd_q.push_back('{name: "unmapped", data: 32'h0, resp: 1'b0});
`endif
        bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b0; bus.HADDR = 12'h040;
        @(posedge nn_clk); #1;
        bus.HSEL = 1'b0; bus.HTRANS = 2'b00;
`ifdef NN_AHB_ERR_RESP_EN
        checkOutput("unmapped_c1_ready", 32'(bus.HREADYOUT), 32'h0);
        checkOutput("unmapped_c1_resp", 32'(bus.HRESP), 32'h1);
`else
        checkOutput("unmapped_c1_ready", 32'(bus.HREADYOUT), 32'h1);
        checkOutput("unmapped_c1_resp", 32'(bus.HRESP), 32'h0);
`endif
        waitDataPhase("unmapped");
        @(posedge nn_clk); #1;

        // Reset in the data phase of a SEED write aborts it
        bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b1; bus.HADDR = 12'h014;
        @(posedge nn_clk); #1;
        bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0; bus.HWDATA = 32'h7777_7777;
        nn_rst = 1'b1;
        @(posedge nn_clk); #1;
        nn_rst = 1'b0;
        @(posedge nn_clk); #1;
        ahbRead(12'h014, 32'h0000_0001, "seed_after_abort");
        ahbRead(12'h000, 32'h0, "cr_after_reset");

        repeat (2) @(posedge nn_clk);
        #1;
        checkOutput("rd_queue_empty", 32'(rd_q.size()), 32'h0);
        checkOutput("cmd_queue_empty", 32'(cmd_q.size()), 32'h0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got no finish, expected finish before 200000");
        $fatal(1, "[TB] timeout");
    end
endmodule
